rv_decode_stage: RTL and testbench
==================================

# rv_decode_stage

Registered, parametrised RV32I/RV64I instruction-decode pipeline stage between fetch and execute. It extracts register fields and immediates, classifies the instruction format, flags memory/control/M-extension operations, and detects illegal encodings. Valid/ready handshakes sit on both sides, with a one-entry skid buffer, flush support and a one-cycle latency.

## Interface
Parameters:
- XLEN, 32: datapath width (32 or 64); sets immediate width, shamt width and legal RV64 loads/stores.
- ENABLE_M, 0: 1 = decode the M extension (funct7 0000001 on opcode R) as legal.
- PC_W, 32: width of the program-counter side-band.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous drop of all held instructions.
- in_valid  in  1  fetch offers an instruction.
- in_ready  out  1  stage can accept; registered.
- in_instr  in  32  raw instruction.
- in_pc  in  PC_W  PC of in_instr.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute accepts the bundle.
- out_pc  out  PC_W  PC side-band.
- out_opcode  out  7  instr[6:0].
- out_rd / out_rs1 / out_rs2  out  5 each  instr[11:7] / [19:15] / [24:20].
- out_funct3  out  3  instr[14:12].
- out_funct7  out  7  instr[31:25].
- out_imm  out  XLEN  sign-extended immediate for the format (shifts: zero-extended shamt).
- out_fmt  out  3  format code: R, I, S, B, U, J or NONE.
- out_ctrl  out  5  {is_muldiv, is_jump, is_branch, is_store, is_load}.
- out_illegal  out  1  encoding not supported under the current parameters.

## Operation
- Opcodes: OP_IMM, JALR, LOAD, LUI, AUIPC, JAL, STORE, BRANCH, OP. Any other opcode, or instr[1:0] != 2'b11, gives illegal=1 and fmt=NONE.
- Immediates are sign-extended to XLEN:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- Shift-immediates: shamt width = log2(XLEN).
  - SLLI requires the upper funct bits = 0.
  - SRLI/SRAI allow only 0 or 0100000 (XLEN=32), or funct6 0/010000 (XLEN=64).
  - Anything else is illegal.
- OP requires one of the following, otherwise illegal:
  - funct7 = 0.
  - funct7 = 0100000 with funct3 000 or 101.
  - funct7 = 0000001 with ENABLE_M=1; this sets is_muldiv.
- All 8 OP funct3 values are decoded, including XOR/OR/AND.
- LOAD funct3:
  - 000/001/010/100/101 legal.
  - 011 and 110 legal only when XLEN=64.
  - 111 illegal.
- STORE funct3: 000–010 legal; 011 legal only when XLEN=64.
- BRANCH funct3 010/011 illegal. JALR requires funct3=000.
- is_jump covers JAL and JALR.
- Illegal bundles still flow through the handshake; execute raises the trap.

## Timing
- Latency: 1 cycle. An instruction accepted at edge k drives the outputs from edge k onward (out_valid=1 in cycle k+1).
- Throughput: 1/cycle while out_ready=1.
- Transfers happen when valid&&ready on the respective side.
- Storage is one output register plus a one-entry skid buffer. in_ready = !skid_valid.
- Backpressure:
  - If out_valid && !out_ready on an accept edge, the new bundle goes to skid; in_ready falls on the next cycle.
  - When out_ready is seen, skid moves to the output register and in_ready returns to 1 the cycle after.
- Simultaneous input accept and output drain with skid empty: the output register is replaced and skid stays empty.
- Order is strictly FIFO.
- flush: at the edge, out_valid=0 and skid_valid=0; in_ready=1 the following cycle.
  - A same-cycle in_valid is dropped; flush beats accept.
- Reset values, including rst asserted mid-operation:
  - out_valid=0, skid_valid=0, in_ready=1.
  - All out_* data = 0, out_fmt=NONE, out_illegal=0.
  - Held contents are discarded; no bundle may appear after rst deasserts without a new accept.
- out_* data must stay stable while out_valid && !out_ready.

## Structure
- Package rv_decode_pkg holds:
  - opcode localparams.
  - fmt enum (R=0, I=1, S=2, B=3, U=4, J=5, NONE=7).
  - ctrl bit indices.
  - a decoded-bundle struct.
- Sub-module rv_decode_comb is purely combinational: instr → bundle, parametrised by XLEN/ENABLE_M.
  - It is instantiated once, on the input side.
  - The top holds the output register, the skid buffer and the handshake.

## Test plan
- ADDI x1,x0,-1 (0xFFF00093), XLEN=32 → next cycle out_valid=1, rd=1, fmt=I, imm=0xFFFFFFFF, illegal=0.
- LW x5,8(x2) (0x00812283) → ctrl=00001 (load), imm=8, rs1=2, rd=5; LD (0x00813283) → illegal=1 at XLEN=32, 0 at XLEN=64.
- BEQ x0,x0,-4 (0xFE000EE3) → fmt=B, is_branch=1, imm=0xFFFFFFFC; JAL x1,+2048 (0x001000EF) → fmt=J, imm=0x800, is_jump=1.
- MUL x3,x1,x2 (0x022081B3) → illegal=1 when ENABLE_M=0; illegal=0 and is_muldiv=1 when ENABLE_M=1. Opcode 0x0F → illegal=1, fmt=NONE.
- out_ready=0, three back-to-back instrs → two accepted, in_ready=0 on the third. Raise out_ready → all three emerge in order, none lost or duplicated, outputs stable while stalled.
- With output and skid full, pulse flush with in_valid=1 → next cycle out_valid=0, in_ready=1, nothing emitted. Repeat with rst asserted asynchronously mid-cycle → immediate return to reset values.

Source files
------------

// File: rtl/rv_decode_pkg.sv
// rv_decode_pkg
//   Shared definitions for the RV32I/RV64I decode stage: base opcodes,
//   instruction format codes, control-bit positions and the decoded bundle
//   carried from the combinational decoder into the stage registers.
//   The immediate is kept outside the bundle because its width follows XLEN.
package rv_decode_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd7
  } fmt_e;

  localparam int CTRL_LOAD   = 0;
  localparam int CTRL_STORE  = 1;
  localparam int CTRL_BRANCH = 2;
  localparam int CTRL_JUMP   = 3;
  localparam int CTRL_MULDIV = 4;
  localparam int CTRL_W      = 5;

  typedef struct packed {
    logic [6:0]        opcode;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    fmt_e              fmt;
    logic [CTRL_W-1:0] ctrl;
    logic              illegal;
  } dec_bundle_t;

  localparam dec_bundle_t BUNDLE_RESET = '{
    opcode:  7'd0,
    rd:      5'd0,
    rs1:     5'd0,
    rs2:     5'd0,
    funct3:  3'd0,
    funct7:  7'd0,
    fmt:     FMT_NONE,
    ctrl:    5'd0,
    illegal: 1'b0
  };

endpackage

// File: rtl/rv_decode_comb.sv
// rv_decode_comb
//   Purely combinational RV32I/RV64I decoder: raw instruction -> bundle.
//   Ports:
//     instr   in  32    raw instruction word
//     bundle  out       register fields, format, control flags, illegal
//     imm     out XLEN  sign-extended immediate (shifts: zero-extended shamt)
module rv_decode_comb
  import rv_decode_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b0
) (
  input  logic [31:0]     instr,
  output dec_bundle_t     bundle,
  output logic [XLEN-1:0] imm
);

  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;
  logic [XLEN-1:0] imm_sh;
  logic [2:0]      funct3;
  logic [6:0]      funct7;

  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  assign imm_i  = XLEN'($signed(instr[31:20]));
  assign imm_s  = XLEN'($signed({instr[31:25], instr[11:7]}));
  assign imm_b  = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
  assign imm_u  = XLEN'($signed({instr[31:12], 12'b0}));
  assign imm_j  = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
  assign imm_sh = XLEN'(instr[20 +: SHW]);

  always_comb begin
    bundle.opcode  = instr[6:0];
    bundle.rd      = instr[11:7];
    bundle.rs1     = instr[19:15];
    bundle.rs2     = instr[24:20];
    bundle.funct3  = funct3;
    bundle.funct7  = funct7;
    bundle.fmt     = FMT_NONE;
    bundle.ctrl    = '0;
    bundle.illegal = 1'b1;
    imm            = '0;

    // Every listed opcode ends in 2'b11, so compressed/reserved encodings
    // fall into the default branch and stay illegal.
    case (instr[6:0])
      OPC_OP_IMM: begin
        bundle.fmt     = FMT_I;
        bundle.illegal = 1'b0;
        imm            = imm_i;
        if (funct3 == 3'b001) begin
          imm            = imm_sh;
          bundle.illegal = |instr[31:20+SHW];
        end else if (funct3 == 3'b101) begin
          // Only bit 30 (arithmetic select) may be set above the shamt.
          imm            = imm_sh;
          bundle.illegal = instr[31] | (|instr[29:20+SHW]);
        end
      end
      OPC_JALR: begin
        bundle.fmt              = FMT_I;
        bundle.ctrl[CTRL_JUMP]  = 1'b1;
        bundle.illegal          = (funct3 != 3'b000);
        imm                     = imm_i;
      end
      OPC_LOAD: begin
        bundle.fmt              = FMT_I;
        bundle.ctrl[CTRL_LOAD]  = 1'b1;
        imm                     = imm_i;
        case (funct3)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: bundle.illegal = 1'b0;
          3'b011, 3'b110:                         bundle.illegal = (XLEN != 64);
          default:                                bundle.illegal = 1'b1;
        endcase
      end
      OPC_STORE: begin
        bundle.fmt              = FMT_S;
        bundle.ctrl[CTRL_STORE] = 1'b1;
        imm                     = imm_s;
        case (funct3)
          3'b000, 3'b001, 3'b010: bundle.illegal = 1'b0;
          3'b011:                 bundle.illegal = (XLEN != 64);
          default:                bundle.illegal = 1'b1;
        endcase
      end
      OPC_BRANCH: begin
        bundle.fmt               = FMT_B;
        bundle.ctrl[CTRL_BRANCH] = 1'b1;
        bundle.illegal           = (funct3 == 3'b010) || (funct3 == 3'b011);
        imm                      = imm_b;
      end
      OPC_LUI, OPC_AUIPC: begin
        bundle.fmt     = FMT_U;
        bundle.illegal = 1'b0;
        imm            = imm_u;
      end
      OPC_JAL: begin
        bundle.fmt             = FMT_J;
        bundle.ctrl[CTRL_JUMP] = 1'b1;
        bundle.illegal         = 1'b0;
        imm                    = imm_j;
      end
      OPC_OP: begin
        bundle.fmt = FMT_R;
        if (funct7 == 7'b0000000) begin
          bundle.illegal = 1'b0;
        end else if (funct7 == 7'b0100000) begin
          bundle.illegal = !((funct3 == 3'b000) || (funct3 == 3'b101));
        end else if ((funct7 == 7'b0000001) && ENABLE_M) begin
          bundle.illegal           = 1'b0;
          bundle.ctrl[CTRL_MULDIV] = 1'b1;
        end
      end
      default: begin
        bundle.fmt     = FMT_NONE;
        bundle.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/rv_decode_stage.sv
// rv_decode_stage
//   Registered decode stage between fetch and execute, one-cycle latency,
//   output register plus one-entry skid buffer, strict FIFO order.
//   Ports:
//     clk, rst                    clock, async active-high reset
//     flush                       synchronous drop of both held entries
//     in_valid/in_ready           fetch handshake (in_ready = !skid_valid)
//     in_instr, in_pc             instruction and its PC
//     out_valid/out_ready         execute handshake
//     out_pc .. out_illegal       registered decoded bundle
module rv_decode_stage
  import rv_decode_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b0,
  parameter int PC_W     = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [4:0]      out_ctrl,
  output logic            out_illegal
);

  dec_bundle_t     in_bundle;
  logic [XLEN-1:0] in_imm;

  dec_bundle_t     out_q;
  logic [XLEN-1:0] out_imm_q;
  logic [PC_W-1:0] out_pc_q;
  logic            out_valid_q;

  dec_bundle_t     skid_q;
  logic [XLEN-1:0] skid_imm_q;
  logic [PC_W-1:0] skid_pc_q;
  logic            skid_valid_q;

  logic            accept;

  rv_decode_comb #(
    .XLEN     (XLEN),
    .ENABLE_M (ENABLE_M)
  ) u_comb (
    .instr  (in_instr),
    .bundle (in_bundle),
    .imm    (in_imm)
  );

  assign in_ready = ~skid_valid_q;
  assign accept   = in_valid & in_ready & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q        <= BUNDLE_RESET;
      out_imm_q    <= '0;
      out_pc_q     <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= BUNDLE_RESET;
      skid_imm_q   <= '0;
      skid_pc_q    <= '0;
      skid_valid_q <= 1'b0;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (skid_valid_q) begin
      // Skid full implies the output register is full and in_ready is low,
      // so the only possible move is skid -> output on a drain.
      if (out_ready) begin
        out_q        <= skid_q;
        out_imm_q    <= skid_imm_q;
        out_pc_q     <= skid_pc_q;
        skid_valid_q <= 1'b0;
      end
    end else if (accept) begin
      if (!out_valid_q || out_ready) begin
        out_q       <= in_bundle;
        out_imm_q   <= in_imm;
        out_pc_q    <= in_pc;
        out_valid_q <= 1'b1;
      end else begin
        skid_q       <= in_bundle;
        skid_imm_q   <= in_imm;
        skid_pc_q    <= in_pc;
        skid_valid_q <= 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_pc      = out_pc_q;
  assign out_opcode  = out_q.opcode;
  assign out_rd      = out_q.rd;
  assign out_rs1     = out_q.rs1;
  assign out_rs2     = out_q.rs2;
  assign out_funct3  = out_q.funct3;
  assign out_funct7  = out_q.funct7;
  assign out_imm     = out_imm_q;
  assign out_fmt     = out_q.fmt;
  assign out_ctrl    = out_q.ctrl;
  assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_rv_decode_stage.sv
// tb_rv_decode_stage
//   Two instances share all inputs: XLEN=32/ENABLE_M=0 (a_*) and
//   XLEN=64/ENABLE_M=1 (b_*). Accepted instructions are pushed to a
//   scoreboard with hand-derived expectations; a negedge monitor pops and
//   compares whenever a bundle transfers to execute.
module tb_rv_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;

  logic        a_in_ready, a_out_valid, a_out_illegal;
  logic [31:0] a_out_pc, a_out_imm;
  logic [6:0]  a_out_opcode, a_out_funct7;
  logic [4:0]  a_out_rd, a_out_rs1, a_out_rs2, a_out_ctrl;
  logic [2:0]  a_out_funct3, a_out_fmt;

  logic        b_in_ready, b_out_valid, b_out_illegal;
  logic [31:0] b_out_pc;
  logic [63:0] b_out_imm;
  logic [6:0]  b_out_opcode, b_out_funct7;
  logic [4:0]  b_out_rd, b_out_rs1, b_out_rs2, b_out_ctrl;
  logic [2:0]  b_out_funct3, b_out_fmt;

  always #5 clk = ~clk;

  rv_decode_stage #(.XLEN(32), .ENABLE_M(1'b0), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_pc(a_out_pc),
    .out_opcode(a_out_opcode), .out_rd(a_out_rd), .out_rs1(a_out_rs1), .out_rs2(a_out_rs2),
    .out_funct3(a_out_funct3), .out_funct7(a_out_funct7), .out_imm(a_out_imm),
    .out_fmt(a_out_fmt), .out_ctrl(a_out_ctrl), .out_illegal(a_out_illegal)
  );

  rv_decode_stage #(.XLEN(64), .ENABLE_M(1'b1), .PC_W(32)) dut64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_pc(b_out_pc),
    .out_opcode(b_out_opcode), .out_rd(b_out_rd), .out_rs1(b_out_rs1), .out_rs2(b_out_rs2),
    .out_funct3(b_out_funct3), .out_funct7(b_out_funct7), .out_imm(b_out_imm),
    .out_fmt(b_out_fmt), .out_ctrl(b_out_ctrl), .out_illegal(b_out_illegal)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [63:0] imm32;
    logic [63:0] imm64;
    logic [2:0]  fmt;
    logic [4:0]  ctrl32;
    logic [4:0]  ctrl64;
    logic        ill32;
    logic        ill64;
  } exp_t;

  exp_t vec[$];
  exp_t sb[$];
  exp_t cur;
  exp_t mon_e;
  int   tests_run = 0;
  int   failures  = 0;

  function automatic exp_t mk(input logic [31:0] instr, input logic [63:0] i32,
                              input logic [63:0] i64, input logic [2:0] fmt,
                              input logic [4:0] c32, input logic [4:0] c64,
                              input logic il32, input logic il64);
    exp_t x;
    x.instr = instr; x.pc = 32'h0; x.imm32 = i32; x.imm64 = i64; x.fmt = fmt;
    x.ctrl32 = c32; x.ctrl64 = c64; x.ill32 = il32; x.ill64 = il64;
    return x;
  endfunction

  // fmt: R0 I1 S2 B3 U4 J5 NONE7; ctrl = {muldiv, jump, branch, store, load}
  task automatic build_table();
    vec.push_back(mk(32'hFFF00093, 64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd1, 5'b00000, 5'b00000, 0, 0)); // ADDI -1
    vec.push_back(mk(32'h00812283, 64'h8, 64'h8, 3'd1, 5'b00001, 5'b00001, 0, 0));                       // LW
    vec.push_back(mk(32'h00813283, 64'h8, 64'h8, 3'd1, 5'b00001, 5'b00001, 1, 0));                       // LD
    vec.push_back(mk(32'hFE000EE3, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd3, 5'b00100, 5'b00100, 0, 0)); // BEQ -4
    vec.push_back(mk(32'h001000EF, 64'h800, 64'h800, 3'd5, 5'b01000, 5'b01000, 0, 0));                   // JAL +2048
    vec.push_back(mk(32'h022081B3, 64'h0, 64'h0, 3'd0, 5'b00000, 5'b10000, 1, 0));                       // MUL
    vec.push_back(mk(32'h0000000F, 64'h0, 64'h0, 3'd7, 5'b00000, 5'b00000, 1, 1));                       // opcode 0x0F
    vec.push_back(mk(32'h4030D093, 64'h3, 64'h3, 3'd1, 5'b00000, 5'b00000, 0, 0));                       // SRAI 3
    vec.push_back(mk(32'h02009093, 64'h0, 64'h20, 3'd1, 5'b00000, 5'b00000, 1, 0));                      // SLLI 32
    vec.push_back(mk(32'h4230D093, 64'h3, 64'h23, 3'd1, 5'b00000, 5'b00000, 1, 0));                      // SRAI 35
    vec.push_back(mk(32'h40208033, 64'h0, 64'h0, 3'd0, 5'b00000, 5'b00000, 0, 0));                       // SUB
    vec.push_back(mk(32'h40209033, 64'h0, 64'h0, 3'd0, 5'b00000, 5'b00000, 1, 1));                       // f7=0100000 f3=001
    vec.push_back(mk(32'h00002063, 64'h0, 64'h0, 3'd3, 5'b00100, 5'b00100, 1, 1));                       // branch f3=010
    vec.push_back(mk(32'h800000B7, 64'h80000000, 64'hFFFFFFFF80000000, 3'd4, 5'b00000, 5'b00000, 0, 0)); // LUI neg
    vec.push_back(mk(32'h12345097, 64'h12345000, 64'h12345000, 3'd4, 5'b00000, 5'b00000, 0, 0));         // AUIPC
    vec.push_back(mk(32'h00000092, 64'h0, 64'h0, 3'd7, 5'b00000, 5'b00000, 1, 1));                       // instr[1:0]=10
    vec.push_back(mk(32'h000010E7, 64'h0, 64'h0, 3'd1, 5'b01000, 5'b01000, 1, 1));                       // JALR f3=001
    vec.push_back(mk(32'hFE112E23, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd2, 5'b00010, 5'b00010, 0, 0)); // SW -4
    vec.push_back(mk(32'hFE113E23, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd2, 5'b00010, 5'b00010, 1, 0)); // SD -4
    foreach (vec[i]) vec[i].pc = 32'h1000 + 32'(i) * 4;
  endtask

  task automatic set_in(input exp_t x);
    in_valid = 1'b1;
    in_instr = x.instr;
    in_pc    = x.pc;
    cur      = x;
  endtask

  // Scoreboard: pop/compare on each output transfer, push on each input accept.
  always @(negedge clk) begin
    if (rst || flush) begin
      sb.delete();
    end else begin
      if (a_out_valid && out_ready) begin
        tests_run++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output: pc=%h with empty scoreboard", a_out_pc);
        end else begin
          mon_e = sb.pop_front();
          if ({a_out_pc, a_out_opcode, a_out_rd, a_out_rs1, a_out_rs2, a_out_funct3, a_out_funct7} !==
              {mon_e.pc, mon_e.instr[6:0], mon_e.instr[11:7], mon_e.instr[19:15], mon_e.instr[24:20],
               mon_e.instr[14:12], mon_e.instr[31:25]}) begin
            failures++;
            $display("FAIL fields32 instr=%h: got pc=%h op=%h rd=%0d rs1=%0d rs2=%0d f3=%0d f7=%h, want pc=%h",
                     mon_e.instr, a_out_pc, a_out_opcode, a_out_rd, a_out_rs1, a_out_rs2,
                     a_out_funct3, a_out_funct7, mon_e.pc);
          end
          tests_run++;
          if ({a_out_imm, a_out_fmt, a_out_ctrl, a_out_illegal} !==
              {mon_e.imm32[31:0], mon_e.fmt, mon_e.ctrl32, mon_e.ill32}) begin
            failures++;
            $display("FAIL decode32 instr=%h: got imm=%h fmt=%0d ctrl=%b ill=%b, want imm=%h fmt=%0d ctrl=%b ill=%b",
                     mon_e.instr, a_out_imm, a_out_fmt, a_out_ctrl, a_out_illegal,
                     mon_e.imm32[31:0], mon_e.fmt, mon_e.ctrl32, mon_e.ill32);
          end
          tests_run++;
          if ({b_out_valid, b_out_pc, b_out_rd, b_out_imm, b_out_fmt, b_out_ctrl, b_out_illegal} !==
              {1'b1, mon_e.pc, mon_e.instr[11:7], mon_e.imm64, mon_e.fmt, mon_e.ctrl64, mon_e.ill64}) begin
            failures++;
            $display("FAIL decode64 instr=%h: got v=%b pc=%h rd=%0d imm=%h fmt=%0d ctrl=%b ill=%b, want pc=%h imm=%h fmt=%0d ctrl=%b ill=%b",
                     mon_e.instr, b_out_valid, b_out_pc, b_out_rd, b_out_imm, b_out_fmt, b_out_ctrl,
                     b_out_illegal, mon_e.pc, mon_e.imm64, mon_e.fmt, mon_e.ctrl64, mon_e.ill64);
          end
        end
      end
      if (in_valid && a_in_ready) sb.push_back(cur);
    end
  end

  task automatic test_reset();
    @(posedge clk); #2;
    tests_run++;
    if ({a_out_valid, a_in_ready, a_out_fmt, a_out_illegal, a_out_ctrl, b_out_valid, b_in_ready} !== 13'b0_1_111_0_00000_0_1) begin
      failures++;
      $display("FAIL reset_ctrl: got v=%b rdy=%b fmt=%0d ill=%b ctrl=%b", a_out_valid, a_in_ready,
               a_out_fmt, a_out_illegal, a_out_ctrl);
    end
    tests_run++;
    if ({a_out_pc, a_out_opcode, a_out_rd, a_out_rs1, a_out_rs2, a_out_funct3, a_out_funct7, a_out_imm, b_out_imm} !== '0) begin
      failures++;
      $display("FAIL reset_data: got pc=%h imm=%h imm64=%h, want all zero", a_out_pc, a_out_imm, b_out_imm);
    end
    rst = 1'b0;
  endtask

  task automatic test_decode();
    out_ready = 1'b1;
    foreach (vec[i]) begin
      @(posedge clk); #2;
      set_in(vec[i]);
      @(posedge clk); #2;
      in_valid = 1'b0;
      tests_run++;
      if (a_out_valid !== 1'b1 || a_out_pc !== vec[i].pc) begin
        failures++;
        $display("FAIL latency idx=%0d: got valid=%b pc=%h, want valid=1 pc=%h", i, a_out_valid, a_out_pc, vec[i].pc);
      end
    end
    @(posedge clk); #2;
  endtask

  task automatic test_back_to_back();
    exp_t x;
    out_ready = 1'b1;
    foreach (vec[i]) begin
      @(posedge clk); #2;
      x = vec[i];
      x.pc = 32'h4000 + 32'(i) * 4;
      set_in(x);
      if (i > 0) begin
        tests_run++;
        if (a_out_valid !== 1'b1 || a_in_ready !== 1'b1 || a_out_pc !== 32'h4000 + 32'(i - 1) * 4) begin
          failures++;
          $display("FAIL throughput idx=%0d: got valid=%b in_ready=%b pc=%h", i, a_out_valid, a_in_ready, a_out_pc);
        end
      end
    end
    @(posedge clk); #2;
    in_valid = 1'b0;
    @(posedge clk); #2;
    tests_run++;
    if (a_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drain: got out_valid=%b, want 0", a_out_valid);
    end
  endtask

  task automatic test_backpressure();
    exp_t x[3];
    for (int i = 0; i < 3; i++) begin
      x[i] = vec[i + 3];
      x[i].pc = 32'h5000 + 32'(i) * 4;
    end
    out_ready = 1'b0;
    @(posedge clk); #2; set_in(x[0]);
    @(posedge clk); #2; set_in(x[1]);
    @(posedge clk); #2; set_in(x[2]);
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_out_pc !== x[0].pc ||
          a_out_imm !== x[0].imm32[31:0] || a_out_fmt !== x[0].fmt) begin
        failures++;
        $display("FAIL stall k=%0d: got in_ready=%b valid=%b pc=%h imm=%h fmt=%0d, want 0 1 %h %h %0d",
                 k, a_in_ready, a_out_valid, a_out_pc, a_out_imm, a_out_fmt,
                 x[0].pc, x[0].imm32[31:0], x[0].fmt);
      end
      @(posedge clk); #2;
    end
    out_ready = 1'b1;
    @(posedge clk); #2;
    tests_run++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b1 || a_out_pc !== x[1].pc) begin
      failures++;
      $display("FAIL skid_move: got in_ready=%b valid=%b pc=%h, want 1 1 %h", a_in_ready, a_out_valid, a_out_pc, x[1].pc);
    end
    @(posedge clk); #2;
    in_valid = 1'b0;
    tests_run++;
    if (a_out_valid !== 1'b1 || a_out_pc !== x[2].pc) begin
      failures++;
      $display("FAIL third_out: got valid=%b pc=%h, want 1 %h", a_out_valid, a_out_pc, x[2].pc);
    end
    @(posedge clk); #2;
    tests_run++;
    if (a_out_valid !== 1'b0 || sb.size() != 0) begin
      failures++;
      $display("FAIL bp_drain: got valid=%b pending=%0d, want 0 0", a_out_valid, sb.size());
    end
  endtask

  task automatic test_flush();
    exp_t x;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #2;
      x = vec[i]; x.pc = 32'h6000 + 32'(i) * 4;
      set_in(x);
    end
    @(posedge clk); #2;
    x = vec[2]; x.pc = 32'h6008;
    set_in(x);
    flush = 1'b1;
    @(posedge clk); #2;
    flush = 1'b0;
    in_valid = 1'b0;
    tests_run++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || b_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush: got out_valid=%b in_ready=%b, want 0 1", a_out_valid, a_in_ready);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #2;
      tests_run++;
      if (a_out_valid !== 1'b0) begin
        failures++;
        $display("FAIL flush_quiet k=%0d: got out_valid=%b pc=%h, want 0", k, a_out_valid, a_out_pc);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t x;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      x = vec[i + 5]; x.pc = 32'h7000 + 32'(i) * 4;
      set_in(x);
    end
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({a_out_valid, a_in_ready, a_out_fmt, a_out_illegal, a_out_ctrl, b_out_valid, b_in_ready} !== 13'b0_1_111_0_00000_0_1) begin
      failures++;
      $display("FAIL async_reset_ctrl: got v=%b rdy=%b fmt=%0d ill=%b ctrl=%b", a_out_valid, a_in_ready,
               a_out_fmt, a_out_illegal, a_out_ctrl);
    end
    tests_run++;
    if ({a_out_pc, a_out_rd, a_out_funct7, a_out_imm, b_out_imm} !== '0) begin
      failures++;
      $display("FAIL async_reset_data: got pc=%h imm=%h imm64=%h, want zero", a_out_pc, a_out_imm, b_out_imm);
    end
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #2;
      tests_run++;
      if (a_out_valid !== 1'b0) begin
        failures++;
        $display("FAIL reset_quiet k=%0d: got out_valid=%b pc=%h, want 0", k, a_out_valid, a_out_pc);
      end
    end
  endtask

  task automatic test_random_stall();
    exp_t x;
    int   idx = 0;
    int   budget = 0;
    bit   acc;
    in_valid = 1'b0;
    while ((idx < vec.size() || sb.size() != 0 || a_out_valid) && budget < 3000) begin
      @(negedge clk);
      acc = in_valid && a_in_ready;
      @(posedge clk); #2;
      if (acc) idx++;
      out_ready = ($urandom_range(0, 3) != 0);
      if (idx < vec.size() && ((in_valid && !acc) || $urandom_range(0, 3) != 0)) begin
        x = vec[idx];
        x.pc = 32'h8000 + 32'(idx) * 4;
        set_in(x);
      end else begin
        in_valid = 1'b0;
      end
      budget++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tests_run++;
    if (budget >= 3000) begin
      failures++;
      $display("FAIL random_timeout: sent=%0d pending=%0d", idx, sb.size());
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = 32'h0; in_pc = 32'h0;
    cur = mk(32'h0, 64'h0, 64'h0, 3'd0, 5'd0, 5'd0, 0, 0);
    build_table();
    test_reset();
    test_decode();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random_stall();
    repeat (3) @(posedge clk);
    #2;
    tests_run++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL leftover: %0d expected bundles never emerged", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
